// File: rtl/mseq_pkg.sv
// rtl/mseq_pkg.sv - shared types and defaults for the m-sequence scheduler
package mseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mseq_state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_FRAME_LEN = 31;
  localparam int DEF_LEN_W     = 5;
  localparam int ZERO_SEED_SUB = 1;

endpackage

// File: rtl/mseq_sched_if.sv
// rtl/mseq_sched_if.sv - requester handshake and serial bit stream of the scheduler
interface mseq_sched_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] seed;
  logic [N_REQ*WIDTH-1:0] poly;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   bit_out;
  logic                   bit_valid;
  logic                   bit_last;
  logic                   busy;

  modport master (
    output req, seed, poly,
    input  grant, done, bit_out, bit_valid, bit_last, busy
  );

  modport slave (
    input  req, seed, poly,
    output grant, done, bit_out, bit_valid, bit_last, busy
  );
endinterface

// File: rtl/mseq_rr_arb.sv
// rtl/mseq_rr_arb.sv - combinational round-robin pick starting at the pointer
module mseq_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx
);
  localparam logic [IDX_W:0] N_C = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0] cand;

  always_comb begin
    any        = 1'b0;
    win_onehot = '0;
    win_idx    = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= N_C) cand = cand - N_C;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                           = 1'b1;
        win_onehot[cand[IDX_W-1:0]]   = 1'b1;
        win_idx                       = cand[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/mseq_sched.sv
// rtl/mseq_sched.sv - round-robin frame scheduler sharing one m-sequence generator
// Optional MSEQ_ZERO_GUARD_EN: substitute all-zero seeds and end frames on phase lock-up.
module mseq_sched
  import mseq_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  mseq_sched_if.slave      bus,
  output logic [WIDTH-1:0] gen_fase,
  output logic [WIDTH-1:0] gen_type,
  input  logic [WIDTH-1:0] gen_fase_new,
  input  logic             gen_sum
);
  localparam int             IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  mseq_state_e state_q, state_nxt;

  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic             bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic             bit_last_q, bit_last_d, busy_q;
  logic [WIDTH-1:0] fase_d, type_d, seed_q, seed_d, load_seed;
  logic [IDX_W-1:0] owner_q, owner_d, rr_ptr, ptr_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic             frame_end;

  logic             arb_any;
  logic [N_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0] arb_idx;

  mseq_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req        (bus.req),
    .ptr        (rr_ptr),
    .any        (arb_any),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx)
  );

`ifdef MSEQ_ZERO_GUARD_EN
  // An all-zero phase never leaves zero, so it is swapped out and also ends a frame.
  assign load_seed = (seed_q == '0) ? WIDTH'(ZERO_SEED_SUB) : seed_q;
  assign frame_end = (cnt == LAST_CNT) || (gen_fase_new == '0);
`else
  assign load_seed = seed_q;
  assign frame_end = (cnt == LAST_CNT);
`endif

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (arb_any) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (frame_end) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    done_d      = '0;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    bit_last_d  = 1'b0;
    fase_d      = gen_fase;
    type_d      = gen_type;
    seed_d      = seed_q;
    owner_d     = owner_q;
    ptr_d       = rr_ptr;
    cnt_d       = cnt;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_onehot;
          owner_d = arb_idx;
          type_d  = bus.poly[arb_idx*WIDTH +: WIDTH];
          seed_d  = bus.seed[arb_idx*WIDTH +: WIDTH];
        end
      end
      LOAD: begin
        fase_d = load_seed;
        cnt_d  = '0;
      end
      RUN: begin
        bit_out_d   = gen_sum;
        bit_valid_d = 1'b1;
        bit_last_d  = frame_end;
        fase_d      = gen_fase_new;
        cnt_d       = cnt + 1'b1;
      end
      DONE: begin
        done_d  = grant_q;
        grant_d = '0;
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      grant_q     <= '0;
      done_q      <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      gen_fase    <= '0;
      gen_type    <= '0;
      seed_q      <= '0;
      owner_q     <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      grant_q     <= grant_d;
      done_q      <= done_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      bit_last_q  <= bit_last_d;
      busy_q      <= (state_nxt != IDLE);
      gen_fase    <= fase_d;
      gen_type    <= type_d;
      seed_q      <= seed_d;
      owner_q     <= owner_d;
      rr_ptr      <= ptr_d;
      cnt         <= cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_last  = bit_last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mseq_sched.sv
// tb/tb_mseq_sched.sv - randomized bench for mseq_sched with a frame-level reference model
module tb_mseq_sched;
  localparam int N  = 2;
  localparam int W  = 4;
  localparam int FL = 31;
  localparam int LW = 5;

  logic CLK_50MHZ = 1'b0;
  logic RST;
  always #10 CLK_50MHZ = ~CLK_50MHZ;

  mseq_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();
  logic [W-1:0] gen_fase, gen_type, gen_fase_new;
  logic         gen_sum;

  // Generator: Fibonacci shift with taps selected by the polynomial type; output is the MSB.
  function automatic logic [W-1:0] gen_next(input logic [W-1:0] p, input logic [W-1:0] t);
    return {p[W-2:0], ^(p & t)};
  endfunction
  assign gen_fase_new = gen_next(gen_fase, gen_type);
  assign gen_sum      = gen_fase[W-1];

  mseq_sched #(.N_REQ(N), .WIDTH(W), .FRAME_LEN(FL), .LEN_W(LW)) dut (
    .CLK_50MHZ    (CLK_50MHZ),
    .RST          (RST),
    .bus          (bus),
    .gen_fase     (gen_fase),
    .gen_type     (gen_type),
    .gen_fase_new (gen_fase_new),
    .gen_sum      (gen_sum)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: m_t counts edges since the grant edge (-1 when idle).
  int         m_t = -1, m_ptr = 0, m_win = 0, m_len = 0, m_c;
  logic [W-1:0] m_poly;
  logic       m_bits [0:FL-1];
  logic [W-1:0] m_fase [0:FL];

  task automatic start_frame(input int c);
    logic [W-1:0] p, np;
    m_win  = c;
    m_t    = 0;
    m_poly = bus.poly[c*W +: W];
    p      = bus.seed[c*W +: W];
`ifdef MSEQ_ZERO_GUARD_EN
    if (p == '0) p = 1;
`endif
    m_fase[0] = p;
    m_len = 0;
    for (int k = 0; k < FL; k++) begin
      m_bits[k]   = p[W-1];
      np          = gen_next(p, m_poly);
      m_fase[k+1] = np;
      m_len       = k + 1;
`ifdef MSEQ_ZERO_GUARD_EN
      if (np == '0) break;
`endif
      p = np;
    end
  endtask

  always @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      m_t   = -1;
      m_ptr = 0;
    end else begin
      if (m_t >= 0) begin
        m_t++;
        if (m_t == m_len + 2) m_ptr = (m_win + 1) % N;
        else if (m_t == m_len + 3) m_t = -1;
      end
      if (m_t < 0) begin
        for (int i = 0; i < N; i++) begin
          m_c = (m_ptr + i) % N;
          if (m_t < 0 && bus.req[m_c]) start_frame(m_c);
        end
      end
    end
  end

  always @(negedge CLK_50MHZ) begin
    if (chk_en && !RST) begin
      logic in_frame, in_bits;
      in_frame = (m_t >= 0) && (m_t <= m_len + 1);
      in_bits  = (m_t >= 2) && (m_t <= m_len + 1);
      check("grant", bus.grant, in_frame ? (32'd1 << m_win) : 32'd0);
      check("busy", bus.busy, in_frame);
      check("done", bus.done, (m_t == m_len + 2) ? (32'd1 << m_win) : 32'd0);
      check("bit_valid", bus.bit_valid, in_bits);
      check("bit_last", bus.bit_last, (m_t == m_len + 1));
      if (in_bits) check("bit_out", bus.bit_out, m_bits[m_t-2]);
      if (m_t >= 1 && m_t <= m_len + 1) check("gen_fase", gen_fase, m_fase[m_t-1]);
      if (in_frame) check("gen_type", gen_type, m_poly);
    end
  end

  task automatic wait_done(output logic [N-1:0] d);
    logic found;
    found = 1'b0;
    d = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK_50MHZ);
      if (bus.done != '0) begin
        d = bus.done;
        found = 1'b1;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK_50MHZ);
      if (bus.bit_valid) found = 1'b1;
    end
    if (!found) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK_50MHZ);
      if (!bus.busy) found = 1'b1;
    end
    if (!found) check("idle_timeout", 32'd0, 32'd1);
    @(negedge CLK_50MHZ);
  endtask

  initial begin
    logic [N-1:0] d;
    logic [1:0]   exp_seq [0:3];
    logic         first_bit;
    int           changes;

    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
    RST = 1'b1;
    bus.req = '0; bus.seed = '0; bus.poly = '0;
    repeat (2) @(negedge CLK_50MHZ);
    check("rst_grant", bus.grant, 0);
    check("rst_done", bus.done, 0);
    check("rst_bit_out", bus.bit_out, 0);
    check("rst_bit_valid", bus.bit_valid, 0);
    check("rst_bit_last", bus.bit_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_gen_fase", gen_fase, 0);
    check("rst_gen_type", gen_type, 0);
    RST = 1'b0;
    chk_en = 1'b1;

    // Single frame, seed 0101 / poly 1101: phase alternates 0101,1010 so bits go 0,1,0,1...
    @(negedge CLK_50MHZ);
    bus.req = 2'b01; bus.seed = 8'h05; bus.poly = 8'h0D;
    @(negedge CLK_50MHZ);
    check("t1_grant", bus.grant, 2'b01);
    bus.req = 2'b00;
    @(negedge CLK_50MHZ);
    check("t1_load_fase", gen_fase, 4'b0101);
    @(negedge CLK_50MHZ);
    check("t1_first_valid", bus.bit_valid, 1);
    check("t1_bit1", bus.bit_out, 0);
    @(negedge CLK_50MHZ);
    check("t1_bit2", bus.bit_out, 1);
    repeat (29) @(negedge CLK_50MHZ);
    check("t1_last", bus.bit_last, 1);
    check("t1_bit31", bus.bit_out, 0);
    @(negedge CLK_50MHZ);
    check("t1_done", bus.done, 2'b01);
    check("t1_valid_off", bus.bit_valid, 0);
    wait_idle();

    // Both held: pointer sits at 1 after requester 0's frame.
    bus.req = 2'b11; bus.seed = 8'h93; bus.poly = 8'h9D;
    for (int i = 0; i < 4; i++) begin
      wait_done(d);
      check("rr_done", d, exp_seq[i]);
    end
    bus.req = 2'b00;
    wait_idle();

    // seed change during RUN does not affect the running frame.
    bus.req = 2'b01; bus.seed = 8'h05; bus.poly = 8'h09;
    repeat (6) @(negedge CLK_50MHZ);
    bus.seed = 8'h0F;
    wait_done(d);
    @(negedge CLK_50MHZ);
    check("t3_grant", bus.grant, 2'b01);
    @(negedge CLK_50MHZ);
    check("t3_new_seed", gen_fase, 4'b1111);
    bus.req = 2'b00;
    wait_idle();

    // Asynchronous reset at bit 10.
    bus.req = 2'b01; bus.seed = 8'h05; bus.poly = 8'h09;
    wait_valid();
    bus.req = 2'b00;
    repeat (9) @(negedge CLK_50MHZ);
    #2 RST = 1'b1;
    #1;
    check("t4_grant", bus.grant, 0);
    check("t4_valid", bus.bit_valid, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_done", bus.done, 0);
    check("t4_fase", gen_fase, 0);
    @(negedge CLK_50MHZ);
    RST = 1'b0;
    bus.req = 2'b10;
    @(negedge CLK_50MHZ);
    check("t4_regrant", bus.grant, 2'b10);
    bus.req = 2'b00;
    wait_idle();

    // Zero seed.
    bus.req = 2'b01; bus.seed = 8'h00; bus.poly = 8'h0D;
    @(negedge CLK_50MHZ);
    bus.req = 2'b00;
    @(negedge CLK_50MHZ);
`ifdef MSEQ_ZERO_GUARD_EN
    check("t5_fase", gen_fase, 4'b0001);
`else
    check("t5_fase", gen_fase, 4'b0000);
`endif
    @(negedge CLK_50MHZ);
    first_bit = bus.bit_out;
    changes = 0;
    for (int i = 1; i < FL; i++) begin
      @(negedge CLK_50MHZ);
      if (bus.bit_out !== first_bit) changes++;
    end
`ifdef MSEQ_ZERO_GUARD_EN
    check("t5_nonconst", (changes > 0), 1);
`else
    check("t5_const", changes, 0);
`endif
    wait_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      @(negedge CLK_50MHZ);
      bus.req  = N'($urandom);
      bus.seed = (N*W)'($urandom);
      bus.poly = (N*W)'($urandom);
    end
    bus.req = '0;
    wait_idle();
    repeat (3) @(negedge CLK_50MHZ);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mseq_sched.md
Name: mseq_sched

Overview:
- Round-robin scheduler that shares one m-sequence generator (combinational next-phase/output datapath, driven by phase + polynomial type) between N_REQ requesters.
- Per frame: arbitrates, loads the winner's seed phase and polynomial, steps the generator FRAME_LEN times, streams registered bits, then signals completion.
- Sits between requester logic and the generator instance at the top level; owns the phase register formerly held at top level.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- WIDTH, 4, generator phase / polynomial width.
- FRAME_LEN, 31, bits per frame (1..2^LEN_W-1).
- LEN_W, 5, bit-counter width.

Ports:
- CLK_50MHZ  in  1  system clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  level request per requester.
- seed  in  N_REQ*WIDTH  packed initial phase; slice i belongs to requester i.
- poly  in  N_REQ*WIDTH  packed polynomial type; slice i belongs to requester i.
- grant  out  N_REQ  one-hot owner of the current frame; 0 when idle.
- done  out  N_REQ  one-cycle pulse to the owner after its last bit.
- gen_fase  out  WIDTH  current phase to generator.
- gen_type  out  WIDTH  latched polynomial to generator.
- gen_fase_new  in  WIDTH  generator next phase (combinational from gen_fase/gen_type).
- gen_sum  in  1  generator output bit for current phase.
- bit_out  out  1  serial m-sequence bit.
- bit_valid  out  1  bit_out qualifier.
- bit_last  out  1  high with final bit of frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; grant, done, bit_out, bit_valid, bit_last, busy = 0; gen_fase, gen_type = 0; rr pointer = 0; counter = 0.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE: if any req is high at edge E0, the winner is the first set req at or after the rr pointer (wrapping). At E0: grant <= onehot(winner), gen_type <= poly[winner], seed[winner] captured, state -> LOAD. With no req, stay in IDLE.
- LOAD (E1): gen_fase <= captured seed, counter <= 0, state -> RUN.
- RUN, each edge:
  - bit_out <= gen_sum, bit_valid <= 1, gen_fase <= gen_fase_new, counter++.
  - When counter == FRAME_LEN-1: bit_last <= 1, state -> DONE.
  - The first valid bit is registered at E2. bit_valid stays high for exactly FRAME_LEN consecutive cycles.
- DONE (1 cycle): bit_valid and bit_last <= 0, done[winner] <= 1 for one cycle, grant <= 0, rr pointer <= (winner+1) mod N_REQ, state -> IDLE.
- Minimum gap between frames: DONE plus IDLE, i.e. request-to-first-bit latency is 2 cycles.
- Requests are not aborting. A frame always completes, even if req[winner] drops during LOAD or RUN.
- seed and poly are sampled only at grant. Later changes have no effect on the current frame.
- Requesters still asserting req after done compete again. Round-robin guarantees alternation when all are held high.
- Asynchronous RST mid-frame: immediate return to reset values. No done pulse. The frame is lost.
- Counter compare uses LEN_W-bit unsigned arithmetic. FRAME_LEN=1 produces a single bit with both bit_valid and bit_last set.

Optional Feature:
- MSEQ_ZERO_GUARD_EN defined:
  - A captured seed of all zeros is replaced with 1 (LSB set) at LOAD, preventing generator lock-up.
  - In RUN, if gen_fase_new == 0 the frame ends early: bit_last is set on that bit, then DONE.
- Undefined: the seed is loaded verbatim and no lock-up check is made. An all-zero seed yields FRAME_LEN constant bits.

Decomposition:
- Package mseq_pkg: state enum (IDLE, LOAD, RUN, DONE), default WIDTH/FRAME_LEN constants, ZERO_SEED_SUB constant (1).
- Sub-module mseq_rr_arb: combinational round-robin pick (req, pointer -> one-hot winner + index).
- FSM, phase register, and counter stay in mseq_sched.

Test Plan:
- Single frame: req=01, seed0=0101, poly0=1101 -> grant=01 at E0, bit_valid high for 31 cycles starting E2, bits match the TB generator model from phase 0101, bit_last on bit 31, done=01 one cycle later.
- Both req held high: grant sequence 01,10,01,10, each frame 31 bits, done pulses alternate, busy low for exactly 1 cycle between frames.
- seed0 changes from 0101 to 1111 during RUN -> current frame unaffected; next grant to requester 0 uses 1111.
- RST asserted at bit 10 -> all outputs 0 immediately with no done pulse; after release with req=10, grant=10 (pointer reset to 0, requester 1 is the only request).
- seed=0000 with MSEQ_ZERO_GUARD_EN -> first gen_fase=0001 and a nonconstant sequence; without the macro -> gen_fase stays 0000 and 31 identical bits.
- FRAME_LEN=1 build: req=01 -> single cycle with bit_valid=bit_last=1, done at next edge.
